// File: rtl/mycpu_pkg.sv
`default_nettype none
// ============================================================================
// mycpu_pkg : shared control-bit positions, size codes and MEM/WB payload
// Rev 1.0
// ============================================================================
package mycpu_pkg;

  localparam int CTRL_SIGN    = 0;
  localparam int CTRL_SIZE_LO = 1;
  localparam int CTRL_SIZE_HI = 3;
  localparam int CTRL_LOAD    = 4;
  localparam int CTRL_STORE   = 5;

  typedef enum logic [2:0] {
    SZ_BYTE = 3'b000,
    SZ_HALF = 3'b001,
    SZ_WORD = 3'b010,
    SZ_WL   = 3'b011,
    SZ_WR   = 3'b100
  } size_e;

  // A bubble is carried as an all-zero payload so every derived output idles at 0.
  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rt;
    logic [4:0]  treg;
    logic        wen;
    logic [5:0]  ctrl;
    logic        misaligned;
  } mem_wb_t;

  function automatic size_e to_size(input logic [2:0] code);
    return size_e'(code);
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = a[0];
      SZ_WORD: mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mycpu_mem_wb_if.sv
`default_nettype none
// ============================================================================
// mycpu_mem_wb_if : synchronous data-SRAM port of the MEM stage
// Rev 1.0
// ============================================================================
interface mycpu_mem_wb_if;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mycpu_load_align.sv
`default_nettype none
// ============================================================================
// mycpu_load_align : lane select, extension and LWL/LWR merge of load data
// Rev 1.0
// ============================================================================
module mycpu_load_align
  import mycpu_pkg::*;
(
  input  logic [31:0] m,
  input  logic [31:0] rt,
  input  logic [1:0]  a,
  input  logic [5:0]  ctrl,
  output logic [31:0] aligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sx;
  logic        unused_ctrl;

  // Load/store bits are decided by the caller; only sign and size matter here.
  assign unused_ctrl = ^ctrl[CTRL_STORE:CTRL_LOAD];

  always_comb begin
    byte_lane = m[{a, 3'b000} +: 8];
    half_lane = a[1] ? m[31:16] : m[15:0];
    sx        = ctrl[CTRL_SIGN];
    aligned   = m;
    case (to_size(ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO]))
      SZ_BYTE: aligned = {{24{sx & byte_lane[7]}}, byte_lane};
      SZ_HALF: aligned = {{16{sx & half_lane[15]}}, half_lane};
      SZ_WORD: aligned = m;
      SZ_WL: begin
        case (a)
          2'd0:    aligned = {m[7:0],  rt[23:0]};
          2'd1:    aligned = {m[15:0], rt[15:0]};
          2'd2:    aligned = {m[23:0], rt[7:0]};
          default: aligned = m;
        endcase
      end
      SZ_WR: begin
        case (a)
          2'd0:    aligned = m;
          2'd1:    aligned = {rt[31:24], m[31:8]};
          2'd2:    aligned = {rt[31:16], m[31:16]};
          default: aligned = {rt[31:8],  m[31:24]};
        endcase
      end
      default: aligned = m;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mycpu_mem_wb.sv
`default_nettype none
// ============================================================================
// mycpu_mem_wb : MEM and WB stages - data SRAM access, load align, RF write
// Rev 1.0
// ============================================================================
module mycpu_mem_wb
  import mycpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [31:0]           in_result,
  input  logic [31:0]           in_rt,
  input  logic [4:0]            in_treg,
  input  logic                  in_wen,
  input  logic [5:0]            in_ctrl,
  mycpu_mem_wb_if.master        sram,
  output logic                  rf_wen,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic [4:0]            tag_mem,
  output logic [4:0]            tag_wb,
  output logic [31:0]           cont_mem,
  output logic [31:0]           cont_wb,
  output logic                  mem_is_load,
  output logic                  exc_valid,
  output logic [31:0]           exc_badvaddr
);

  logic        mem_valid_q, mem_valid_d;
  logic        wb_valid_q,  wb_valid_d;
  mem_wb_t     mem_q, mem_d;
  mem_wb_t     wb_q,  wb_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  size_e       mem_size;
  logic [1:0]  mem_a;
  logic        mem_go;
  logic        mem_store_go;
  logic [3:0]  st_wen;
  logic [31:0] st_wdata;
  logic [31:0] load_value;

  // Misalignment is resolved on entry so MEM and WB both see one registered flag.
  always_comb begin : p_next
    mem_valid_d = in_valid;
    mem_d       = '0;
    if (in_valid) begin
      mem_d.result     = in_result;
      mem_d.rt         = in_rt;
      mem_d.treg       = in_treg;
      mem_d.wen        = in_wen;
      mem_d.ctrl       = in_ctrl;
      mem_d.misaligned = (in_ctrl[CTRL_LOAD] | in_ctrl[CTRL_STORE]) &
                         is_misaligned(to_size(in_ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO]),
                                       in_result[1:0]);
    end
    wb_valid_d = mem_valid_q;
    wb_d       = mem_q;
    badvaddr_d = exc_valid ? mem_q.result : badvaddr_q;
  end

  always_comb begin : p_store_lanes
    mem_size = to_size(mem_q.ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO]);
    mem_a    = mem_q.result[1:0];
    st_wen   = 4'b0000;
    st_wdata = '0;
    case (mem_size)
      SZ_BYTE: begin
        st_wen   = 4'b0001 << mem_a;
        st_wdata = {4{mem_q.rt[7:0]}};
      end
      SZ_HALF: begin
        st_wen   = mem_a[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_q.rt[15:0]}};
      end
      SZ_WORD: begin
        st_wen   = 4'b1111;
        st_wdata = mem_q.rt;
      end
      // SWL fills the low lanes up to a, SWR the high lanes from a.
      SZ_WL: begin
        st_wen   = 4'b1111 >> ~mem_a;
        st_wdata = mem_q.rt >> {~mem_a, 3'b000};
      end
      SZ_WR: begin
        st_wen   = 4'b1111 << mem_a;
        st_wdata = mem_q.rt << {mem_a, 3'b000};
      end
      default: begin
        st_wen   = 4'b0000;
        st_wdata = '0;
      end
    endcase
  end

  assign mem_go       = mem_valid_q & (mem_q.ctrl[CTRL_LOAD] | mem_q.ctrl[CTRL_STORE]) &
                        ~mem_q.misaligned;
  assign mem_store_go = mem_go & mem_q.ctrl[CTRL_STORE];

  assign sram.data_sram_en    = mem_go;
  assign sram.data_sram_addr  = mem_go ? {mem_q.result[31:2], 2'b00} : '0;
  assign sram.data_sram_wen   = mem_store_go ? st_wen : 4'b0000;
  assign sram.data_sram_wdata = mem_store_go ? st_wdata : '0;

  // The faulting address is visible during the pulse and held afterwards.
  assign exc_valid    = mem_valid_q & mem_q.misaligned;
  assign exc_badvaddr = badvaddr_d;

  assign tag_mem     = (mem_valid_q & mem_q.wen & ~mem_q.misaligned) ? mem_q.treg : 5'd0;
  assign cont_mem    = mem_q.result;
  assign mem_is_load = mem_valid_q & mem_q.ctrl[CTRL_LOAD];

  mycpu_load_align u_load_align (
    .m       (sram.data_sram_rdata),
    .rt      (wb_q.rt),
    .a       (wb_q.result[1:0]),
    .ctrl    (wb_q.ctrl),
    .aligned (load_value)
  );

  assign rf_wen   = wb_valid_q & wb_q.wen & ~wb_q.misaligned & (wb_q.treg != 5'd0);
  assign rf_waddr = wb_q.treg;
  assign rf_wdata = wb_q.ctrl[CTRL_LOAD] ? load_value : wb_q.result;
  assign tag_wb   = rf_wen ? wb_q.treg : 5'd0;
  assign cont_wb  = rf_wdata;

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      mem_q       <= '0;
      wb_q        <= '0;
      badvaddr_q  <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      badvaddr_q  <= badvaddr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mycpu_mem_wb.sv
`default_nettype none
// ============================================================================
// tb_mycpu_mem_wb : scoreboard bench for the MEM/WB back end
// Rev 1.0
// ============================================================================
module tb_mycpu_mem_wb;

  localparam logic [5:0] C_ALU = 6'b000000;
  localparam logic [5:0] C_LB  = 6'b010001;
  localparam logic [5:0] C_LBU = 6'b010000;
  localparam logic [5:0] C_LH  = 6'b010011;
  localparam logic [5:0] C_LHU = 6'b010010;
  localparam logic [5:0] C_LW  = 6'b010100;
  localparam logic [5:0] C_LWL = 6'b010110;
  localparam logic [5:0] C_LWR = 6'b011000;
  localparam logic [5:0] C_SB  = 6'b100000;
  localparam logic [5:0] C_SH  = 6'b100010;
  localparam logic [5:0] C_SW  = 6'b100100;
  localparam logic [5:0] C_SWL = 6'b100110;
  localparam logic [5:0] C_SWR = 6'b101000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_wen;
  logic [31:0] in_result, in_rt;
  logic [4:0]  in_treg;
  logic [5:0]  in_ctrl;
  logic        rf_wen, mem_is_load, exc_valid;
  logic [4:0]  rf_waddr, tag_mem, tag_wb;
  logic [31:0] rf_wdata, cont_mem, cont_wb, exc_badvaddr;

  mycpu_mem_wb_if sram();

  mycpu_mem_wb dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_result(in_result), .in_rt(in_rt),
    .in_treg(in_treg), .in_wen(in_wen), .in_ctrl(in_ctrl),
    .sram(sram),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .tag_mem(tag_mem), .tag_wb(tag_wb), .cont_mem(cont_mem), .cont_wb(cont_wb),
    .mem_is_load(mem_is_load), .exc_valid(exc_valid), .exc_badvaddr(exc_badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
  } sram_exp_t;
  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_exp_t;

  sram_exp_t   sram_q[$];
  rf_exp_t     rf_q[$];
  logic [31:0] exc_q[$];
  sram_exp_t   mon_se;
  rf_exp_t     mon_re;
  logic [31:0] mon_exc;

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Byte-addressed data SRAM: one-cycle read latency, writes land at the edge.
  logic [31:0] mem_model [logic [29:0]];
  logic [31:0] model_word;
  logic [29:0] model_idx;

  always @(posedge clk) begin
    if (rst) begin
      sram.data_sram_rdata <= '0;
    end else if (sram.data_sram_en) begin
      model_idx  = sram.data_sram_addr[31:2];
      model_word = mem_model.exists(model_idx) ? mem_model[model_idx] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (sram.data_sram_wen[i]) model_word[8*i +: 8] = sram.data_sram_wdata[8*i +: 8];
      mem_model[model_idx] = model_word;
      sram.data_sram_rdata <= model_word;
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a request or write.
  always @(negedge clk) begin
    if (!rst) begin
      if (sram.data_sram_en) begin
        if (sram_q.size() == 0) begin
          check("sram_unexpected_en", {31'd0, sram.data_sram_en}, 32'd0);
        end else begin
          mon_se = sram_q.pop_front();
          check("sram_wen", {28'd0, sram.data_sram_wen}, {28'd0, mon_se.wen});
          check("sram_addr", sram.data_sram_addr, mon_se.addr);
          if (mon_se.chk_wdata) check("sram_wdata", sram.data_sram_wdata, mon_se.wdata);
        end
      end
      if (rf_wen) begin
        if (rf_q.size() == 0) begin
          check("rf_unexpected_wen", {31'd0, rf_wen}, 32'd0);
        end else begin
          mon_re = rf_q.pop_front();
          check("rf_waddr", {27'd0, rf_waddr}, {27'd0, mon_re.waddr});
          check("rf_wdata", rf_wdata, mon_re.wdata);
        end
      end
      if (exc_valid) begin
        check("exc_no_sram_en", {31'd0, sram.data_sram_en}, 32'd0);
        if (exc_q.size() == 0) begin
          check("exc_unexpected", {31'd0, exc_valid}, 32'd0);
        end else begin
          mon_exc = exc_q.pop_front();
          check("exc_badvaddr", exc_badvaddr, mon_exc);
        end
      end
    end
  end

  function automatic logic [29:0] widx(input logic [31:0] a);
    return a[31:2];
  endfunction

  task automatic drive(input logic v, input logic [5:0] c, input logic [31:0] res,
                       input logic [31:0] rt, input logic [4:0] t, input logic w);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_ctrl   = c;
    in_result = res;
    in_rt     = rt;
    in_treg   = t;
    in_wen    = w;
  endtask

  task automatic bubble();
    drive(1'b0, C_ALU, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic exp_store(input logic [3:0] wen, input logic [31:0] waddr, input logic [31:0] wdata);
    sram_q.push_back('{wen, waddr, wdata, 1'b1});
  endtask

  task automatic exp_load(input logic [31:0] waddr, input logic [4:0] t, input logic [31:0] val);
    sram_q.push_back('{4'b0000, waddr, 32'h0, 1'b0});
    rf_q.push_back('{t, val});
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_sram_pending"}, sram_q.size(), 32'd0);
    check({tag, "_rf_pending"}, rf_q.size(), 32'd0);
    check({tag, "_exc_pending"}, exc_q.size(), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; in_wen = 0; in_result = 0; in_rt = 0; in_treg = 0; in_ctrl = 0;
    mem_model[widx(32'h0000_1000)] = 32'h80AA_BBCC;
    mem_model[widx(32'h0000_2000)] = 32'hAABB_CCDD;
    mem_model[widx(32'h0000_6000)] = 32'h8001_FF7F;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_sram_en", {31'd0, sram.data_sram_en}, 32'd0);
    check("reset_rf", {rf_wen, rf_waddr, tag_mem, tag_wb}, 32'd0);
    check("reset_exc", {31'd0, exc_valid}, 32'd0);
    check("reset_badvaddr", exc_badvaddr, 32'd0);
    check("reset_cont_wb", cont_wb, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back directed stream, one operation per cycle.
    drive(1, C_SB,  32'h0000_1001, 32'h1122_3344, 5'd0,  1'b0); exp_store(4'b0010, 32'h1000, 32'h4444_4444);
    drive(1, C_LB,  32'h0000_1003, 32'h0,         5'd1,  1'b1); exp_load(32'h1000, 5'd1, 32'hFFFF_FF80);
    drive(1, C_LBU, 32'h0000_1003, 32'h0,         5'd2,  1'b1); exp_load(32'h1000, 5'd2, 32'h0000_0080);
    drive(1, C_LWL, 32'h0000_2001, 32'h1122_3344, 5'd3,  1'b1); exp_load(32'h2000, 5'd3, 32'hCCDD_3344);
    drive(1, C_LWR, 32'h0000_2001, 32'h1122_3344, 5'd4,  1'b1); exp_load(32'h2000, 5'd4, 32'h11AA_BBCC);
    drive(1, C_SW,  32'h0000_4000, 32'hDEAD_BEEF, 5'd0,  1'b0); exp_store(4'b1111, 32'h4000, 32'hDEAD_BEEF);
    drive(1, C_LW,  32'h0000_4000, 32'h0,         5'd5,  1'b1); exp_load(32'h4000, 5'd5, 32'hDEAD_BEEF);
    drive(1, C_LB,  32'h0000_4002, 32'h0,         5'd6,  1'b1); exp_load(32'h4000, 5'd6, 32'hFFFF_FFAD);
    drive(1, C_LH,  32'h0000_6002, 32'h0,         5'd7,  1'b1); exp_load(32'h6000, 5'd7, 32'hFFFF_8001);
    drive(1, C_LHU, 32'h0000_6000, 32'h0,         5'd8,  1'b1); exp_load(32'h6000, 5'd8, 32'h0000_FF7F);
    drive(1, C_LB,  32'h0000_6000, 32'h0,         5'd9,  1'b1); exp_load(32'h6000, 5'd9, 32'h0000_007F);
    drive(1, C_SH,  32'h0000_5006, 32'h1122_3344, 5'd0,  1'b0); exp_store(4'b1100, 32'h5004, 32'h3344_3344);
    drive(1, C_SWL, 32'h0000_5002, 32'h1122_3344, 5'd0,  1'b0); exp_store(4'b0111, 32'h5000, 32'h0011_2233);
    drive(1, C_SWR, 32'h0000_5001, 32'h1122_3344, 5'd0,  1'b0); exp_store(4'b1110, 32'h5000, 32'h2233_4400);
    drive(1, C_ALU, 32'h1234_5678, 32'h0,         5'd10, 1'b1); rf_q.push_back('{5'd10, 32'h1234_5678});
    drive(1, C_SH,  32'h0000_5005, 32'h1122_3344, 5'd0,  1'b0); exc_q.push_back(32'h0000_5005);
    drive(1, C_LW,  32'h0000_3002, 32'h0,         5'd11, 1'b1); exc_q.push_back(32'h0000_3002);
    drive(1, C_LWL, 32'h0000_5003, 32'h0,         5'd12, 1'b1); exp_load(32'h5000, 5'd12, 32'h2233_4433);
    drive(1, C_LW,  32'h0000_5004, 32'h0,         5'd13, 1'b1); exp_load(32'h5004, 5'd13, 32'h3344_0000);
    repeat (4) bubble();
    @(negedge clk);
    check_queues_empty("stream");
    check("badvaddr_held", exc_badvaddr, 32'h0000_3002);
    check("exc_idle", {31'd0, exc_valid}, 32'd0);

    // Forwarding tags and values, ALU op then load.
    drive(1, C_ALU, 32'hA5A5_0001, 32'h0, 5'd10, 1'b1); rf_q.push_back('{5'd10, 32'hA5A5_0001});
    bubble();
    @(negedge clk);
    check("fwd_tag_mem", {27'd0, tag_mem}, 32'd10);
    check("fwd_cont_mem", cont_mem, 32'hA5A5_0001);
    check("fwd_alu_not_load", {31'd0, mem_is_load}, 32'd0);
    bubble();
    @(negedge clk);
    check("fwd_tag_wb", {27'd0, tag_wb}, 32'd10);
    check("fwd_cont_wb", cont_wb, 32'hA5A5_0001);
    check("fwd_tag_mem_bubble", {27'd0, tag_mem}, 32'd0);

    drive(1, C_LW, 32'h0000_4000, 32'h0, 5'd14, 1'b1); exp_load(32'h4000, 5'd14, 32'hDEAD_BEEF);
    bubble();
    @(negedge clk);
    check("ld_mem_is_load", {31'd0, mem_is_load}, 32'd1);
    check("ld_tag_mem", {27'd0, tag_mem}, 32'd14);
    bubble();
    @(negedge clk);
    check("ld_tag_wb", {27'd0, tag_wb}, 32'd14);
    check("ld_cont_wb", cont_wb, 32'hDEAD_BEEF);

    // Write to $0 followed by bubbles: never a write, tags stay 0.
    drive(1, C_ALU, 32'h0000_FFFF, 32'h0, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bubble();
      @(negedge clk);
      check("r0_tag_mem", {27'd0, tag_mem}, 32'd0);
      check("r0_tag_wb", {27'd0, tag_wb}, 32'd0);
      check("r0_rf_wen", {31'd0, rf_wen}, 32'd0);
    end
    check_queues_empty("r0");

    // Reset while a load sits in MEM and an ALU op in WB: both are dropped.
    drive(1, C_ALU, 32'h0000_0055, 32'h0, 5'd8, 1'b1);
    drive(1, C_LW,  32'h0000_1000, 32'h0, 5'd7, 1'b1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    check("prerst_sram_en", {31'd0, sram.data_sram_en}, 32'd1);
    check("prerst_rf_wen", {31'd0, rf_wen}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_sram", {sram.data_sram_en, sram.data_sram_wen, 27'd0}, 32'd0);
    check("rst_sram_addr", sram.data_sram_addr, 32'd0);
    check("rst_sram_wdata", sram.data_sram_wdata, 32'd0);
    check("rst_rf_ctl", {rf_wen, rf_waddr, tag_mem, tag_wb, mem_is_load, exc_valid}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_cont_mem", cont_mem, 32'd0);
    check("rst_cont_wb", cont_wb, 32'd0);
    check("rst_badvaddr", exc_badvaddr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_rf_wen", {31'd0, rf_wen}, 32'd0);
      check("postrst_sram_en", {31'd0, sram.data_sram_en}, 32'd0);
    end
    check_queues_empty("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
